regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//   Owns the single register-file write port (WE3/A3/WD3) in the 5-stage core.
//   Shares it between the in-order WB stage and a long-latency unit (LU, e.g. mul/div).
//   Keeps a per-register pending scoreboard for LU destinations and raises the decode stall.
//   Sits between WB/LU and register_file, and feeds ID-stage hazard logic.
// PARAMETERS
//   XLEN          32  data width of a register
//   REG_AW        5   register address width (2**REG_AW registers; x0 hard-wired zero)
//   FIFO_DEPTH    2   LU result buffer entries (power of 2, >=2)
//   STARVE_LIMIT  4   consecutive cycles with FIFO full before wb_hold is raised
// PORTS
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous, active-high
//   wb_we        in   1       WB stage write request (never back-pressured)
//   wb_rd        in   REG_AW  WB destination register
//   wb_data      in   XLEN    WB write data
//   lu_valid     in   1       LU result valid
//   lu_rd        in   REG_AW  LU destination register
//   lu_data      in   XLEN    LU result data
//   lu_ready     out  1       LU result accepted when lu_valid&lu_ready
//   issue_valid  in   1       ID issues an LU op this cycle (marks issue_rd pending)
//   issue_rd     in   REG_AW  destination of the issued LU op
//   id_rs1       in   REG_AW  ID source 1, for hazard query
//   id_rs2       in   REG_AW  ID source 2, for hazard query
//   id_rd        in   REG_AW  ID destination, for WAW query
//   id_stall     out  1       ID must stall (RAW/WAW on pending LU destination)
//   wb_hold      out  1       request pipeline freeze so the LU FIFO can drain
//   rf_we        out  1       to register_file WE3
//   rf_a3        out  REG_AW  to register_file A3
//   rf_wd        out  XLEN    to register_file WD3
// BEHAVIOUR
//   Reset: FIFO empty, scoreboard all 0, starve counter 0. While reset is high: rf_we=0,
//     lu_ready=0, id_stall=0, wb_hold=0, rf_a3=0, rf_wd=0.
//   Write mux (combinational, 0-cycle latency):
//     - WB wins when wb_we && wb_rd!=0 -> rf_we=1, rf_a3=wb_rd, rf_wd=wb_data.
//     - Otherwise, if FIFO not empty -> write the FIFO head and pop it on this clock edge.
//     - Otherwise rf_we=0. No write is ever issued to x0.
//   LU handshake: lu_ready = !full. Push on lu_valid&&lu_ready, at the clock edge.
//     - A push to an empty FIFO is not visible before the next cycle.
//       There is no bypass of lu_data to rf_* in the push cycle.
//     - Push and pop in the same cycle are legal; the FIFO is ordered, with wrap-around
//       pointers.
//     - LU results with lu_rd==0 are accepted and discarded (not pushed).
//   Scoreboard pending[r]:
//     - Set on issue_valid && issue_rd!=0.
//     - Cleared when an LU entry for r is written to the register file (pop edge).
//     - If r is set and cleared in the same cycle, set wins.
//     - pending[0] is always 0.
//   id_stall = pending[id_rs1] | pending[id_rs2] | pending[id_rd] (x0 operands ignored).
//     - Uses the registered scoreboard only; no forwarding from the FIFO.
//   Starvation: cnt increments each cycle with FIFO full and the port taken by WB;
//     otherwise it resets to 0.
//     - wb_hold is registered: it goes 1 the cycle after cnt reaches STARVE_LIMIT-1,
//       and stays 1 until the FIFO is not full.
//     - Contract: the pipeline presents wb_we=0 on the cycle after wb_hold rises.
//   Illegal (assertion only, no recovery): WB writing an r with pending[r]=1;
//     issue_valid to an r already pending.
//   Reset mid-operation discards FIFO contents and pending bits without writing them.
// STRUCTURE
//   Shared header regfile_defs.vh: XLEN, REG_AW, and the wr_req_t fields {rd, data}.
//   One sub-module: wr_fifo (synchronous FIFO with full/empty, async reset) holding LU
//   results. Scoreboard, starvation counter and write mux stay in this module.
// TESTING
//   1 WB only: wb_we=1, wb_rd=5, data=0x11 -> same cycle rf_we=1, a3=5, wd=0x11;
//     wb_rd=0 -> rf_we=0.
//   2 LU drain: issue rd=7, then LU result 7/0xAB with WB idle -> written the next cycle,
//     pending[7] clears, and id_stall for rs1=7 drops the cycle after the write.
//   3 Collision: WB and FIFO both want the port -> WB is written first; LU x9 is written
//     the first cycle WB is idle; FIFO order is kept for results 3 then 4.
//   4 Full/back-pressure: WB busy every cycle, 3 LU results -> lu_ready=0 after 2 pushes;
//     wb_hold=1 after STARVE_LIMIT cycles; WB idles, 2 pops follow, wb_hold falls.
//   5 Same-cycle set/clear: pop of rd=6 while issuing rd=6 -> pending[6] stays 1.
//   6 Reset mid-op: FIFO 2 deep and 3 regs pending, reset pulse -> lu_ready=0 and
//     rf_we=0 during reset; afterwards FIFO empty, no stall, no spurious writes.

Source files
------------

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: data/address widths
// and the buffered write request carried through the LU result FIFO.
package regfile_wport_arbiter_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wr_req_t;
endpackage

// File: rtl/regfile_wport_arbiter_wr_fifo.sv
// Ordered LU result buffer. Wrap-around pointers carry one extra bit so that
// full and empty are told apart without a separate counter.
module regfile_wport_arbiter_wr_fifo
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  wr_req_t push_data_i,
    input  logic    pop_i,
    output wr_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int AW = $clog2(DEPTH);

    wr_req_t       mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: entries are only ever read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// Owns the register-file write port: WB has priority, buffered LU results fill
// idle cycles. Tracks pending LU destinations for the ID stall and WB starvation.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_data,
    output logic              lu_ready,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    output logic              id_stall,
    output logic              wb_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

    wr_req_t          fifo_head;
    wr_req_t          push_req;
    logic             fifo_full, fifo_empty;
    logic             wb_win, fifo_pop, lu_push, starve;
    logic [NREG-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_hold_q, wb_hold_d;

    assign wb_win   = wb_we && (wb_rd != '0);
    assign fifo_pop = !wb_win && !fifo_empty;
    assign lu_ready = !fifo_full && !reset;
    // x0 results are handshaken but never enter the buffer.
    assign lu_push  = lu_valid && lu_ready && (lu_rd != '0);
    assign push_req = '{rd: lu_rd, data: lu_data};
    assign starve   = fifo_full && wb_win;

    regfile_wport_arbiter_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (lu_push),
        .push_data_i (push_req),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        if (!reset) begin
            if (wb_win) begin
                rf_we = 1'b1;
                rf_a3 = wb_rd;
                rf_wd = wb_data;
            end else if (fifo_pop) begin
                rf_we = 1'b1;
                rf_a3 = fifo_head.rd;
                rf_wd = fifo_head.data;
            end
        end
    end

    // Clear before set so a same-cycle issue to the popped register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) pending_d[fifo_head.rd] = 1'b0;
        if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    assign id_stall = !reset && (pending_q[id_rs1] | pending_q[id_rs2] | pending_q[id_rd]);

    always_comb begin
        cnt_d = '0;
        if (starve) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        wb_hold_d = (wb_hold_q || (starve && (cnt_q == CNT_MAX))) &&
                    fifo_full && !(fifo_pop && !lu_push);
    end

    assign wb_hold = wb_hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
            wb_hold_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            wb_hold_q <= wb_hold_d;
        end
    end

    a_wb_to_pending: assert property (@(posedge clk) disable iff (reset)
        !(wb_win && pending_q[wb_rd]));
    a_issue_to_pending: assert property (@(posedge clk) disable iff (reset)
        !(issue_valid && (issue_rd != '0) && pending_q[issue_rd]));
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: inputs change on the falling edge,
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_regfile_wport_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_stall, wb_hold, rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    regfile_wport_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_stall    (id_stall),
        .wb_hold     (wb_hold),
        .rf_we       (rf_we),
        .rf_a3       (rf_a3),
        .rf_wd       (rf_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_we = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        issue_valid = 0; issue_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_we = 1; wb_rd = rd; wb_data = d;
    endtask

    task automatic lu(input logic [4:0] rd, input logic [31:0] d);
        lu_valid = 1; lu_rd = rd; lu_data = d;
    endtask

    task automatic chk_lu_write(input string tag);
        logic [36:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 40'd0, 40'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_we"}, {39'd0, rf_we}, 40'd1);
            chk({tag, "_wr"}, {3'd0, rf_a3, rf_wd}, {3'd0, e});
        end
    endtask

    initial begin
        reset = 1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rf_we", {39'd0, rf_we}, 40'd0);
        chk("rst_lu_ready", {39'd0, lu_ready}, 40'd0);
        chk("rst_id_stall", {39'd0, id_stall}, 40'd0);
        chk("rst_wb_hold", {39'd0, wb_hold}, 40'd0);
        chk("rst_rf_a3", {35'd0, rf_a3}, 40'd0);
        chk("rst_rf_wd", {8'd0, rf_wd}, 40'd0);
        reset = 0;
        next();

        // WB only
        wb(5, 32'h11); #1;
        chk("t1_we", {39'd0, rf_we}, 40'd1);
        chk("t1_a3", {35'd0, rf_a3}, 40'd5);
        chk("t1_wd", {8'd0, rf_wd}, 40'h11);
        chk("t1_lu_ready", {39'd0, lu_ready}, 40'd1);
        next();
        wb(0, 32'h22); #1;
        chk("t1_x0_we", {39'd0, rf_we}, 40'd0);
        next(); idle();

        // LU drain with scoreboard
        issue_valid = 1; issue_rd = 7; #1;
        next();
        issue_valid = 0; id_rs1 = 7; lu(7, 32'hAB); #1;
        chk("t2_stall_set", {39'd0, id_stall}, 40'd1);
        chk("t2_no_bypass", {39'd0, rf_we}, 40'd0);
        next();
        lu_valid = 0; #1;
        chk("t2_wr_we", {39'd0, rf_we}, 40'd1);
        chk("t2_wr", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd7, 32'hAB});
        chk("t2_stall_hold", {39'd0, id_stall}, 40'd1);
        next(); #1;
        chk("t2_stall_clr", {39'd0, id_stall}, 40'd0);
        chk("t2_idle_we", {39'd0, rf_we}, 40'd0);
        next(); idle();

        // LU result to x0 is accepted and dropped
        lu(0, 32'hDEAD); #1;
        chk("tx0_ready", {39'd0, lu_ready}, 40'd1);
        next(); idle(); #1;
        chk("tx0_no_write", {39'd0, rf_we}, 40'd0);
        next();

        // Collision: WB first, then FIFO in order
        exp_q.push_back({5'd9, 32'h99});
        exp_q.push_back({5'd3, 32'h33});
        exp_q.push_back({5'd4, 32'h44});
        wb(1, 32'h1); lu(9, 32'h99); #1;
        chk("t3_wb_a", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd1, 32'h1});
        next();
        wb(2, 32'h2); lu(3, 32'h33); #1;
        chk("t3_wb_b", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd2, 32'h2});
        chk("t3_ready_b", {39'd0, lu_ready}, 40'd1);
        next();
        wb_we = 0; lu(4, 32'h44); #1;
        chk("t3_full_ready", {39'd0, lu_ready}, 40'd0);
        chk_lu_write("t3_pop9");
        next(); #1;
        chk("t3_ready_d", {39'd0, lu_ready}, 40'd1);
        chk_lu_write("t3_pop3");
        next();
        lu_valid = 0; #1;
        chk_lu_write("t3_pop4");
        next(); #1;
        chk("t3_drained", {39'd0, rf_we}, 40'd0);
        next(); idle();

        // Back-pressure and starvation
        wb(10, 32'h100); lu(20, 32'h200); #1;
        next();
        wb(10, 32'h101); lu(21, 32'h201); #1;
        chk("t4_ready_1", {39'd0, lu_ready}, 40'd1);
        next();
        for (int i = 0; i < 4; i++) begin
            wb(10, 32'h102 + i); lu(22, 32'h202); #1;
            chk("t4_full_ready", {39'd0, lu_ready}, 40'd0);
            chk("t4_hold_low", {39'd0, wb_hold}, 40'd0);
            chk("t4_wb_owns", {35'd0, rf_a3}, 40'd10);
            next();
        end
        wb_we = 0; #1;
        chk("t4_hold_high", {39'd0, wb_hold}, 40'd1);
        chk("t4_pop20", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd20, 32'h200});
        next(); #1;
        chk("t4_hold_fall", {39'd0, wb_hold}, 40'd0);
        chk("t4_ready_back", {39'd0, lu_ready}, 40'd1);
        chk("t4_pop21", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd21, 32'h201});
        next();
        lu_valid = 0; #1;
        chk("t4_pop22", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd22, 32'h202});
        next(); #1;
        chk("t4_drained", {39'd0, rf_we}, 40'd0);
        next(); idle();

        // Same-cycle set and clear of pending[6]
        lu(6, 32'h66); id_rs1 = 6; #1;
        chk("t5_not_pending", {39'd0, id_stall}, 40'd0);
        next();
        lu_valid = 0; issue_valid = 1; issue_rd = 6; #1;
        chk("t5_pop6", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd6, 32'h66});
        next();
        issue_valid = 0; id_rs1 = 0; id_rs2 = 6; lu(6, 32'h67); #1;
        chk("t5_set_wins_rs2", {39'd0, id_stall}, 40'd1);
        next();
        lu_valid = 0; id_rs2 = 0; id_rd = 6; #1;
        chk("t5_waw", {39'd0, id_stall}, 40'd1);
        chk("t5_pop6b", {3'd0, rf_a3, rf_wd}, {3'd0, 5'd6, 32'h67});
        next(); #1;
        chk("t5_cleared", {39'd0, id_stall}, 40'd0);
        next(); idle();

        // Reset in the middle of activity
        for (int r = 11; r <= 13; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            next();
        end
        issue_valid = 0;
        wb(1, 32'h5); lu(14, 32'h14);
        next();
        lu(15, 32'h15);
        next();
        lu_valid = 0; id_rs1 = 11; #1;
        chk("t6_pre_full", {39'd0, lu_ready}, 40'd0);
        chk("t6_pre_stall", {39'd0, id_stall}, 40'd1);
        reset = 1; #1;
        chk("t6_rst_we", {39'd0, rf_we}, 40'd0);
        chk("t6_rst_ready", {39'd0, lu_ready}, 40'd0);
        chk("t6_rst_stall", {39'd0, id_stall}, 40'd0);
        chk("t6_rst_a3wd", {3'd0, rf_a3, rf_wd}, 40'd0);
        next();
        reset = 0; idle(); id_rs1 = 11; id_rs2 = 12; id_rd = 13; #1;
        chk("t6_post_stall", {39'd0, id_stall}, 40'd0);
        chk("t6_post_we", {39'd0, rf_we}, 40'd0);
        chk("t6_post_ready", {39'd0, lu_ready}, 40'd1);
        chk("t6_post_hold", {39'd0, wb_hold}, 40'd0);
        next(); #1;
        chk("t6_post_we2", {39'd0, rf_we}, 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
